nmea_gga_parser: RTL and testbench

- Byte-stream consumer placed directly downstream of uart_rx; takes its d_out/valid pair.
- Recognises NMEA $GPGGA sentences from the GPS module and verifies the XOR checksum.
- Extracts UTC time, latitude, longitude, hemisphere flags and fix quality as BCD for the navigation logic.
- Outputs hold the last checksum-good sentence; they update atomically with a 1-cycle strobe.

---
 rtl/nmea_gga_parser.sv | 231 +++++++++++++++++++++++
 tb/tb_nmea_gga_parser.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmea_gga_parser.sv
// nmea_gga_parser: recognises $GPGGA (or $xxGGA) sentences from a byte stream,
// verifies the XOR checksum and publishes time/position/fix fields as BCD.
module nmea_gga_parser #(
  parameter int unsigned MAX_LEN    = 82,
  parameter bit          TALKER_ANY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d_in,
  input  logic        in_valid,
  output logic [23:0] utc_bcd,
  output logic [31:0] lat_bcd,
  output logic        lat_s,
  output logic [35:0] lon_bcd,
  output logic        lon_w,
  output logic [3:0]  fix_q,
  output logic        fix_valid,
  output logic        chk_err,
  output logic        busy
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
  localparam int unsigned FLD_W = 3;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned HDR_W = 3;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_E      = 8'h45;
  localparam logic [7:0] CH_F      = 8'h46;
  localparam logic [7:0] CH_G      = 8'h47;
  localparam logic [7:0] CH_N      = 8'h4E;
  localparam logic [7:0] CH_P      = 8'h50;
  localparam logic [7:0] CH_S      = 8'h53;
  localparam logic [7:0] CH_W      = 8'h57;
  localparam logic [7:0] CH_Z      = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FIELD = 3'd2,
    ST_CHK1  = 3'd3,
    ST_CHK2  = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_cnt;
  logic [HDR_W-1:0] hdr_idx;
  logic [FLD_W-1:0] fld_idx;
  logic [DIG_W-1:0] dig_cnt;
  logic [7:0]       acc;
  logic [3:0]       chk_hi;

  logic [23:0]      utc_sh;
  logic [31:0]      lat_sh;
  logic             lat_s_sh;
  logic [35:0]      lon_sh;
  logic             lon_w_sh;
  logic [3:0]       fix_q_sh;

  logic             is_digit_c;
  logic             is_upper_c;
  logic             is_hex_c;
  logic [3:0]       hex_val_c;
  logic             len_over_c;
  logic [7:0]       hdr_char_c;
  logic             hdr_ok_c;
  logic             fld_ok_c;

  // Classification of the incoming byte
  always_comb begin
    is_digit_c = (d_in >= CH_0) && (d_in <= CH_9);
    is_upper_c = (d_in >= CH_A) && (d_in <= CH_Z);
    is_hex_c   = is_digit_c || ((d_in >= CH_A) && (d_in <= CH_F));
    hex_val_c  = is_digit_c ? d_in[3:0] : 4'(d_in[3:0] + 4'd9);
    len_over_c = (len_cnt == LEN_W'(MAX_LEN));
  end

  // Header character match and per-field character legality
  always_comb begin
    hdr_char_c = CH_COMMA;
    case (hdr_idx)
      3'd0:    hdr_char_c = CH_G;
      3'd1:    hdr_char_c = CH_P;
      3'd2:    hdr_char_c = CH_G;
      3'd3:    hdr_char_c = CH_G;
      3'd4:    hdr_char_c = CH_A;
      default: hdr_char_c = CH_COMMA;
    endcase
    hdr_ok_c = (d_in == hdr_char_c);
    if (TALKER_ANY && (hdr_idx < 3'd2)) hdr_ok_c = is_upper_c;

    fld_ok_c = 1'b1;
    case (fld_idx)
      3'd1, 3'd2, 3'd4, 3'd6: fld_ok_c = is_digit_c || (d_in == CH_DOT);
      3'd3, 3'd5:             fld_ok_c = (d_in == CH_N) || (d_in == CH_S) ||
                                         (d_in == CH_E) || (d_in == CH_W);
      default:                fld_ok_c = 1'b1;
    endcase
  end

  // busy is a pure decode of the state register
  assign busy = (state != ST_IDLE);

  // Sentence FSM, shadow capture and atomic commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_cnt   <= '0;
      hdr_idx   <= '0;
      fld_idx   <= '0;
      dig_cnt   <= '0;
      acc       <= '0;
      chk_hi    <= '0;
      utc_sh    <= '0;
      lat_sh    <= '0;
      lat_s_sh  <= 1'b0;
      lon_sh    <= '0;
      lon_w_sh  <= 1'b0;
      fix_q_sh  <= '0;
      utc_bcd   <= '0;
      lat_bcd   <= '0;
      lat_s     <= 1'b0;
      lon_bcd   <= '0;
      lon_w     <= 1'b0;
      fix_q     <= '0;
      fix_valid <= 1'b0;
      chk_err   <= 1'b0;
    end else begin
      fix_valid <= 1'b0;
      chk_err   <= 1'b0;
      if (in_valid) begin
        if (d_in == CH_DOLLAR) begin
          state    <= ST_HDR;
          len_cnt  <= LEN_W'(1);
          hdr_idx  <= '0;
          fld_idx  <= '0;
          dig_cnt  <= '0;
          acc      <= '0;
          utc_sh   <= '0;
          lat_sh   <= '0;
          lat_s_sh <= 1'b0;
          lon_sh   <= '0;
          lon_w_sh <= 1'b0;
          fix_q_sh <= '0;
        end else if (state != ST_IDLE) begin
          len_cnt <= len_cnt + LEN_W'(1);
          if (len_over_c) begin
            state <= ST_IDLE;
          end else begin
            case (state)
              ST_HDR: begin
                if (!hdr_ok_c) begin
                  state <= ST_IDLE;
                end else begin
                  acc <= acc ^ d_in;
                  if (hdr_idx == 3'd5) begin
                    state   <= ST_FIELD;
                    fld_idx <= FLD_W'(1);
                    dig_cnt <= '0;
                  end else begin
                    hdr_idx <= hdr_idx + 3'd1;
                  end
                end
              end
              ST_FIELD: begin
                if (d_in == CH_STAR) begin
                  state <= ST_CHK1;
                end else if (d_in == CH_COMMA) begin
                  acc     <= acc ^ d_in;
                  dig_cnt <= '0;
                  if (fld_idx != '1) fld_idx <= fld_idx + FLD_W'(1);
                end else if (!fld_ok_c) begin
                  state <= ST_IDLE;
                end else begin
                  acc <= acc ^ d_in;
                  if (fld_idx == 3'd3 && d_in == CH_S) lat_s_sh <= 1'b1;
                  if (fld_idx == 3'd5 && d_in == CH_W) lon_w_sh <= 1'b1;
                  if (is_digit_c) begin
                    if (dig_cnt != '1) dig_cnt <= dig_cnt + DIG_W'(1);
                    case (fld_idx)
                      3'd1: for (int unsigned k = 0; k < 6; k++)
                              if (dig_cnt == DIG_W'(k)) utc_sh[4*(5-k) +: 4] <= d_in[3:0];
                      3'd2: for (int unsigned k = 0; k < 8; k++)
                              if (dig_cnt == DIG_W'(k)) lat_sh[4*(7-k) +: 4] <= d_in[3:0];
                      3'd4: for (int unsigned k = 0; k < 9; k++)
                              if (dig_cnt == DIG_W'(k)) lon_sh[4*(8-k) +: 4] <= d_in[3:0];
                      3'd6: if (dig_cnt == '0) fix_q_sh <= d_in[3:0];
                      default: ;
                    endcase
                  end
                end
              end
              ST_CHK1: begin
                if (is_hex_c) begin
                  chk_hi <= hex_val_c;
                  state  <= ST_CHK2;
                end else begin
                  state <= ST_IDLE;
                end
              end
              ST_CHK2: begin
                state <= ST_IDLE;
                if (is_hex_c) begin
                  if ({chk_hi, hex_val_c} == acc) begin
                    utc_bcd   <= utc_sh;
                    lat_bcd   <= lat_sh;
                    lat_s     <= lat_s_sh;
                    lon_bcd   <= lon_sh;
                    lon_w     <= lon_w_sh;
                    fix_q     <= fix_q_sh;
                    fix_valid <= 1'b1;
                  end else begin
                    chk_err <= 1'b1;
                  end
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nmea_gga_parser.sv
// tb_nmea_gga_parser: directed and random sentences fed to a strict-talker and
// a relaxed-talker parser, compared against a sentence-level reference model.
module tb_nmea_gga_parser;

  localparam int unsigned MAX_LEN = 82;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  d_in;
  logic        in_valid;

  logic [23:0] utc_o   [2];
  logic [31:0] lat_o   [2];
  logic        lat_s_o [2];
  logic [35:0] lon_o   [2];
  logic        lon_w_o [2];
  logic [3:0]  fq_o    [2];
  logic        fv_o    [2];
  logic        ce_o    [2];
  logic        busy_o  [2];

  always #5 clk = ~clk;

  nmea_gga_parser #(.MAX_LEN(MAX_LEN), .TALKER_ANY(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid),
    .utc_bcd(utc_o[0]), .lat_bcd(lat_o[0]), .lat_s(lat_s_o[0]),
    .lon_bcd(lon_o[0]), .lon_w(lon_w_o[0]), .fix_q(fq_o[0]),
    .fix_valid(fv_o[0]), .chk_err(ce_o[0]), .busy(busy_o[0])
  );

  nmea_gga_parser #(.MAX_LEN(MAX_LEN), .TALKER_ANY(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid),
    .utc_bcd(utc_o[1]), .lat_bcd(lat_o[1]), .lat_s(lat_s_o[1]),
    .lon_bcd(lon_o[1]), .lon_w(lon_w_o[1]), .fix_q(fq_o[1]),
    .fix_valid(fv_o[1]), .chk_err(ce_o[1]), .busy(busy_o[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int fv_cnt [2];
  int ce_cnt [2];
  int both_cnt = 0;

  logic [23:0] e_utc   [2];
  logic [31:0] e_lat   [2];
  logic        e_lat_s [2];
  logic [35:0] e_lon   [2];
  logic        e_lon_w [2];
  logic [3:0]  e_fq    [2];

  byte unsigned seg[$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      fv_cnt[k] = 0;
      ce_cnt[k] = 0;
    end
  end

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (fv_o[k] === 1'b1) fv_cnt[k]++;
      if (ce_o[k] === 1'b1) ce_cnt[k]++;
      if (fv_o[k] === 1'b1 && ce_o[k] === 1'b1) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_dig(input byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_up(input byte unsigned c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic bit is_uhex(input byte unsigned c);
    return is_dig(c) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  function automatic int hex_v(input byte unsigned c);
    return is_dig(c) ? int'(c) - 48 : int'(c) - 55;
  endfunction

  function automatic byte unsigned hex_ch(input logic [3:0] v, input bit lower);
    if (v < 4'd10) return 8'(8'h30 + v);
    return 8'((lower ? 8'h61 : 8'h41) + v - 8'd10);
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) seg.push_back(s[i]);
  endtask

  task automatic push_digits(input int n);
    for (int i = 0; i < n; i++) seg.push_back(8'(8'h30 + $urandom_range(0, 9)));
  endtask

  // mode 0: correct checksum, 1: off by one, 2: correct but lowercase hex
  task automatic append_checksum(input int mode);
    byte unsigned x;
    x = 8'h00;
    for (int i = 1; i < seg.size(); i++) x ^= seg[i];
    if (mode == 1) x = 8'(x + 8'd1);
    seg.push_back(8'h2A);
    seg.push_back(hex_ch(x[7:4], mode == 2));
    seg.push_back(hex_ch(x[3:0], mode == 2));
    push_str("\r\n");
  endtask

  // Sentence-level reference: kind 0 = nothing, 1 = commit, 2 = checksum error
  function automatic void model(input bit ta, output int kind,
                                output logic [23:0] utc, output logic [31:0] lat,
                                output logic ls, output logic [35:0] lon,
                                output logic lw, output logic [3:0] fq);
    int n, star, fld, kept;
    int nd [1:6];
    int lim [1:6];
    logic [63:0] v [1:6];
    byte unsigned x, c;
    kind = 0; utc = '0; lat = '0; ls = 1'b0; lon = '0; lw = 1'b0; fq = '0;
    lim[1] = 6; lim[2] = 8; lim[3] = 0; lim[4] = 9; lim[5] = 0; lim[6] = 1;
    for (int f = 1; f <= 6; f++) begin
      nd[f] = 0;
      v[f]  = '0;
    end
    n = seg.size();
    if (n < 7) return;
    if (seg[0] != 8'h24) return;
    if (ta) begin
      if (!(is_up(seg[1]) && is_up(seg[2]))) return;
    end else if (seg[1] != "G" || seg[2] != "P") return;
    if (seg[3] != "G" || seg[4] != "G" || seg[5] != "A" || seg[6] != ",") return;
    star = -1;
    for (int i = 7; i < n; i++) begin
      if (seg[i] == "*") begin
        star = i;
        break;
      end
    end
    if (star < 0 || star + 2 >= n) return;
    if (star + 3 > int'(MAX_LEN)) return;
    x = 8'h00;
    for (int i = 1; i < star; i++) x ^= seg[i];
    fld = 1;
    for (int i = 7; i < star; i++) begin
      c = seg[i];
      if (c == ",") begin
        fld++;
        continue;
      end
      if (fld == 1 || fld == 2 || fld == 4 || fld == 6) begin
        if (!is_dig(c) && c != ".") return;
      end else if (fld == 3 || fld == 5) begin
        if (!(c == "N" || c == "S" || c == "E" || c == "W")) return;
      end
      if (fld == 3 && c == "S") ls = 1'b1;
      if (fld == 5 && c == "W") lw = 1'b1;
      if (fld <= 6 && is_dig(c)) begin
        nd[fld]++;
        if (nd[fld] <= lim[fld]) v[fld] = (v[fld] * 16) + 64'(c - 8'h30);
      end
    end
    if (!is_uhex(seg[star + 1]) || !is_uhex(seg[star + 2])) return;
    kept = (nd[1] < 6) ? nd[1] : 6;
    utc  = 24'(v[1] << (4 * (6 - kept)));
    kept = (nd[2] < 8) ? nd[2] : 8;
    lat  = 32'(v[2] << (4 * (8 - kept)));
    kept = (nd[4] < 9) ? nd[4] : 9;
    lon  = 36'(v[4] << (4 * (9 - kept)));
    fq   = 4'(v[6]);
    kind = (hex_v(seg[star + 1]) * 16 + hex_v(seg[star + 2]) == int'(x)) ? 1 : 2;
  endfunction

  task automatic send_byte(input byte unsigned b);
    @(negedge clk);
    d_in     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input int k);
    check($sformatf("%s_d%0d_utc", tag, k), 64'(utc_o[k]), 64'(e_utc[k]));
    check($sformatf("%s_d%0d_lat", tag, k), 64'(lat_o[k]), 64'(e_lat[k]));
    check($sformatf("%s_d%0d_lat_s", tag, k), 64'(lat_s_o[k]), 64'(e_lat_s[k]));
    check($sformatf("%s_d%0d_lon", tag, k), 64'(lon_o[k]), 64'(e_lon[k]));
    check($sformatf("%s_d%0d_lon_w", tag, k), 64'(lon_w_o[k]), 64'(e_lon_w[k]));
    check($sformatf("%s_d%0d_fix_q", tag, k), 64'(fq_o[k]), 64'(e_fq[k]));
  endtask

  // Feed the current segment to both parsers and compare against the model
  task automatic run_seg(input string tag, input bit want_idle);
    int fv0 [2];
    int ce0 [2];
    int kind;
    logic [23:0] m_utc;
    logic [31:0] m_lat;
    logic [35:0] m_lon;
    logic        m_ls, m_lw;
    logic [3:0]  m_fq;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      fv0[k] = fv_cnt[k];
      ce0[k] = ce_cnt[k];
    end
    for (int i = 0; i < seg.size(); i++) send_byte(seg[i]);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      model(k == 1, kind, m_utc, m_lat, m_ls, m_lon, m_lw, m_fq);
      if (kind == 1) begin
        e_utc[k] = m_utc; e_lat[k] = m_lat; e_lat_s[k] = m_ls;
        e_lon[k] = m_lon; e_lon_w[k] = m_lw; e_fq[k] = m_fq;
      end
      check($sformatf("%s_d%0d_fv_pulses", tag, k), 64'(fv_cnt[k] - fv0[k]), (kind == 1) ? 64'd1 : 64'd0);
      check($sformatf("%s_d%0d_ce_pulses", tag, k), 64'(ce_cnt[k] - ce0[k]), (kind == 2) ? 64'd1 : 64'd0);
      check_outs(tag, k);
      if (kind != 0 || want_idle) check($sformatf("%s_d%0d_busy", tag, k), 64'(busy_o[k]), 64'd0);
    end
  endtask

  task automatic clear_expect();
    for (int k = 0; k < 2; k++) begin
      e_utc[k] = '0; e_lat[k] = '0; e_lat_s[k] = 1'b0;
      e_lon[k] = '0; e_lon_w[k] = 1'b0; e_fq[k] = '0;
    end
  endtask

  task automatic gen_random();
    int r;
    seg.delete();
    r = $urandom_range(0, 19);
    push_str("$");
    case (r)
      0:       push_str("GPRMC");
      1:       push_str("GNGGA");
      2:       push_str("gpGGA");
      3:       push_str("GLGGA");
      default: push_str("GPGGA");
    endcase
    push_str(",");
    push_digits($urandom_range(0, 8));
    if ($urandom_range(0, 1) == 1) begin
      push_str(".");
      push_digits($urandom_range(0, 3));
    end
    push_str(",");
    if (r == 5 || $urandom_range(0, 4) != 0) begin
      push_digits($urandom_range(1, 5));
      push_str((r == 5) ? "x" : ".");
      push_digits($urandom_range(0, 6));
    end
    push_str(",");
    case ($urandom_range(0, 3))
      0: push_str("N");
      1: push_str("S");
      2: push_str("E");
      default: ;
    endcase
    push_str(",");
    if ($urandom_range(0, 4) != 0) begin
      push_digits($urandom_range(1, 5));
      push_str(".");
      push_digits($urandom_range(0, 6));
    end
    push_str(",");
    case ($urandom_range(0, 3))
      0: push_str("E");
      1: push_str("W");
      2: push_str("N");
      default: ;
    endcase
    push_str(",");
    if ($urandom_range(0, 3) != 0) push_digits(1);
    push_str(",08,0.9,545.4,M,46.9,M,,");
    if (r == 4) push_digits($urandom_range(10, 40));
    append_checksum((r == 6) ? 1 : ((r == 7) ? 2 : 0));
  endtask

  initial begin
    rst      = 1'b1;
    d_in     = 8'h00;
    in_valid = 1'b0;
    clear_expect();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check_outs("reset", k);
      check($sformatf("reset_d%0d_busy", k), 64'(busy_o[k]), 64'd0);
      check($sformatf("reset_d%0d_fv", k), 64'(fv_o[k]), 64'd0);
      check($sformatf("reset_d%0d_ce", k), 64'(ce_o[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Reference sentence with known field values
    seg.delete();
    push_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n");
    run_seg("clean", 1'b1);
    check("clean_utc_const", 64'(utc_o[0]), 64'h123519);
    check("clean_lat_const", 64'(lat_o[0]), 64'h48070380);
    check("clean_lon_const", 64'(lon_o[0]), 64'h011310000);
    check("clean_fixq_const", 64'(fq_o[0]), 64'd1);

    seg.delete();
    push_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48\r\n");
    run_seg("badsum", 1'b1);

    seg.delete();
    push_str("$GPGGA,235959,3355.120,S,15112.500,W,2,08,0.9,545.4,M,46.9,M,,");
    append_checksum(0);
    run_seg("south_west", 1'b1);
    check("sw_lat_s_const", 64'(lat_s_o[0]), 64'd1);
    check("sw_lon_w_const", 64'(lon_w_o[0]), 64'd1);

    seg.delete();
    push_str("$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W");
    append_checksum(0);
    run_seg("rmc", 1'b1);

    seg.delete();
    push_str("$GNGGA,101010,1234.5678,N,12345.6789,E,4,08,0.9,545.4,M,46.9,M,,");
    append_checksum(0);
    run_seg("gngga", 1'b1);

    // Restart mid-field, then a complete sentence
    seg.delete();
    push_str("$GPGGA,0955,12");
    run_seg("truncated", 1'b0);
    seg.delete();
    push_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n");
    run_seg("after_restart", 1'b1);

    // Reset in the middle of a sentence
    seg.delete();
    push_str("$GPGGA,0955");
    run_seg("pre_rst", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    clear_expect();
    for (int k = 0; k < 2; k++) begin
      check_outs("mid_rst", k);
      check($sformatf("mid_rst_d%0d_busy", k), 64'(busy_o[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // 90-byte sentence with no checksum delimiter
    seg.delete();
    push_str("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,");
    while (seg.size() < 90) push_str("7");
    run_seg("overlength", 1'b1);

    seg.delete();
    push_str("$GPGGA,000001,,,,,0,00,,,M,,M,,");
    append_checksum(0);
    run_seg("empty_pos", 1'b1);
    check("empty_lat_const", 64'(lat_o[0]), 64'd0);
    check("empty_lon_const", 64'(lon_o[0]), 64'd0);
    check("empty_fixq_const", 64'(fq_o[0]), 64'd0);
    check("empty_utc_const", 64'(utc_o[0]), 64'h000001);

    for (int t = 0; t < 60; t++) begin
      gen_random();
      run_seg($sformatf("rnd%0d", t), 1'b0);
    end

    check("pulse_overlap", 64'(both_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
